// File: rtl/xbar_pkg.sv
// ----------------------------------------------------------------------------
// xbar_pkg
// Shared crossbar definitions. It holds the forward-arbiter state encoding and
// a small index-width helper. The helper keeps one-entry vectors at a legal
// width of at least 1.
// ----------------------------------------------------------------------------
package xbar_pkg;

    // Forward arbiter states. IDLE looks for a requester. BURST owns the
    // slave until the last beat of the burst is accepted.
    typedef enum logic [0:0] {
        FA_IDLE  = 1'b0,
        FA_BURST = 1'b1
    } fwd_arb_state_e;

    // Width of an index into an n-entry vector. Never smaller than 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/forward_arbiter_rr_index_picker.sv
// ----------------------------------------------------------------------------
// rr_index_picker
// Combinational round-robin search. It returns the first set bit of req at or
// after ptr. The search wraps from width-1 back to 0.
//
// Ports:
//   req    in  [width-1:0]  candidate request bits
//   ptr    in  [IW-1:0]     search start position (expected < width)
//   found  out 1            at least one request bit is set
//   index  out [IW-1:0]     winning position (0 when nothing is found)
// ----------------------------------------------------------------------------
module rr_index_picker
    import xbar_pkg::*;
#(
    parameter int width = 2
) (
    input  logic [width-1:0]            req,
    input  logic [idx_width(width)-1:0] ptr,
    output logic                        found,
    output logic [idx_width(width)-1:0] index
);

    localparam int IW = idx_width(width);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Walk the offsets from ptr upward and keep the first hit. The wrap uses
    // an explicit compare and subtract, so a width that is not a power of
    // two never lands on a position that does not exist.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < width; off++) begin
            cand = int'(ptr) + off;
            if (cand >= width) begin
                cand = cand - width;
            end
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/forward_arbiter.sv
// ----------------------------------------------------------------------------
// forward_arbiter
// Per-slave arbiter for the forward (master-to-slave) path. It watches the head
// of every master request FIFO and picks a master whose head targets this
// slave. It keeps that grant for the whole burst and then moves the
// round-robin pointer past the winner.
//
// Ports:
//   ACLK                 in   clock
//   ARESETn              in   synchronous active-low reset
//   master_fifo_empty    in   [masters-1:0] per-master request FIFO empty
//   master_slave_dest    in   [SW-1:0] x masters, decoded destination of heads
//   master_last          in   [masters-1:0] head beat is last of its burst
//   slave_ready          in   slave accepts a beat this cycle
//   grant_valid          out  a master holds the burst lock
//   grant_master_number  out  [MW-1:0] granted master (holds value when idle)
//   beat_valid           out  granted FIFO has a head beat present
//   fifo_pop             out  [masters-1:0] one-hot pop to the granted FIFO
// ----------------------------------------------------------------------------
module forward_arbiter
    import xbar_pkg::*;
#(
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [masters-1:0]         master_fifo_empty,
    input  logic [$clog2(slaves)-1:0]  master_slave_dest [0:masters-1],
    input  logic [masters-1:0]         master_last,
    input  logic                       slave_ready,
    output logic                       grant_valid,
    output logic [$clog2(masters)-1:0] grant_master_number,
    output logic                       beat_valid,
    output logic [masters-1:0]         fifo_pop
);

    localparam int MW = $clog2(masters);
    localparam int SW = $clog2(slaves);

    fwd_arb_state_e state, state_next;
    logic [MW-1:0]  rr_ptr, rr_ptr_next;
    logic [MW-1:0]  grant_reg, grant_next;
    logic [masters-1:0] req;
    logic           pick_found;
    logic [MW-1:0]  pick_index;

    // A master requests this slave when its FIFO head exists and its decoded
    // destination matches this instance.
    always_comb begin
        req = '0;
        for (int i = 0; i < masters; i++) begin
            req[i] = ~master_fifo_empty[i] &
                     (master_slave_dest[i] == SW'(i_am_slave_number));
        end
    end

    rr_index_picker #(
        .width (masters)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_index)
    );

    // State, pointer and grant registers. Reset returns the arbiter to IDLE
    // with the search starting at master 0.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= FA_IDLE;
            rr_ptr    <= '0;
            grant_reg <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            grant_reg <= grant_next;
        end
    end

    // Next-state and output logic. The grant depends only on registered state,
    // so a fresh request cannot reach fifo_pop in the same cycle. All outputs
    // are forced quiet while reset is held. A pop at that point would drop a
    // beat that the reset arbiter no longer tracks.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        grant_next  = grant_reg;
        grant_valid = 1'b0;
        beat_valid  = 1'b0;
        fifo_pop    = '0;

        if (ARESETn) begin
            case (state)
                FA_IDLE: begin
                    if (pick_found) begin
                        grant_next = pick_index;
                        state_next = FA_BURST;
                    end
                end

                FA_BURST: begin
                    // The grant stays locked for the burst. An empty head only
                    // stalls the burst. A changed destination on the head is
                    // ignored.
                    grant_valid = 1'b1;
                    beat_valid  = ~master_fifo_empty[grant_reg];
                    if (beat_valid && slave_ready) begin
                        fifo_pop[grant_reg] = 1'b1;
                        if (master_last[grant_reg]) begin
                            state_next  = FA_IDLE;
                            rr_ptr_next = (grant_reg == MW'(masters - 1)) ?
                                          '0 : grant_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_next = FA_IDLE;
                end
            endcase
        end
    end

    assign grant_master_number = grant_reg;

endmodule

// File: tb/tb_forward_arbiter.sv
// ----------------------------------------------------------------------------
// tb_forward_arbiter
// Self-checking bench for forward_arbiter. It has two instances:
//   dutA: masters=4, slaves=2, serves slave 0
//   dutB: masters=3, slaves=4, serves slave 2
// A burst-ownership model inside the bench predicts every output, cycle by
// cycle. Directed scenarios run first, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_forward_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESETn;

    logic [3:0] emptyA, lastA, popA;
    logic [0:0] destA [0:3];
    logic       readyA, gvA, bvA;
    logic [1:0] gmA;

    logic [2:0] emptyB, lastB, popB;
    logic [1:0] destB [0:2];
    logic       readyB, gvB, bvB;
    logic [1:0] gmB;

    // Values the next cycle will drive. applyStimulus copies them onto the
    // pins just after the clock edge.
    logic       nRst;
    logic [3:0] nEmptyA, nLastA;
    logic [0:0] nDestA [0:3];
    logic       nReadyA;
    logic [2:0] nEmptyB, nLastB;
    logic [1:0] nDestB [0:2];
    logic       nReadyB;

    // Model state: owner of the slave (-1 when free), round-robin start and
    // the last granted master.
    int ownerA = -1, rrA = 0, lgA = 0;
    int ownerB = -1, rrB = 0, lgB = 0;

    int  checks   = 0;
    int  failures = 0;
    bit  checksOn = 1'b0;

    always #5 ACLK = ~ACLK;

    forward_arbiter #(.masters(4), .slaves(2), .i_am_slave_number(0)) dutA (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .master_fifo_empty(emptyA), .master_slave_dest(destA),
        .master_last(lastA), .slave_ready(readyA),
        .grant_valid(gvA), .grant_master_number(gmA),
        .beat_valid(bvA), .fifo_pop(popA)
    );

    forward_arbiter #(.masters(3), .slaves(4), .i_am_slave_number(2)) dutB (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .master_fifo_empty(emptyB), .master_slave_dest(destB),
        .master_last(lastB), .slave_ready(readyB),
        .grant_valid(gvB), .grant_master_number(gmB),
        .beat_valid(bvB), .fifo_pop(popB)
    );

    // Single comparison point. It counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Behavioural burst-ownership model. A free slave is handed to the first
    // requester found from the round-robin start (modulo m). The owner keeps it
    // until a pop carries the last flag. The start then moves to the owner
    // plus one.
    task automatic modelStep(input int m, input int slaveNo,
                             input logic [3:0] empty, input int dest[4],
                             input logic [3:0] last, input logic ready,
                             input logic rstn,
                             input int ownerIn, input int rrIn, input int lgIn,
                             output logic expGv, output logic expBv,
                             output logic [3:0] expPop,
                             output int ownerOut, output int rrOut,
                             output int lgOut);
        int c;
        ownerOut = ownerIn;
        rrOut    = rrIn;
        lgOut    = lgIn;
        expGv    = 1'b0;
        expBv    = 1'b0;
        expPop   = 4'b0;
        if (!rstn) begin
            ownerOut = -1;
            rrOut    = 0;
            lgOut    = 0;
        end else if (ownerIn < 0) begin
            for (int k = 0; k < m; k++) begin
                c = (rrIn + k) % m;
                if (ownerOut < 0 && !empty[c[1:0]] && dest[c] == slaveNo)
                    ownerOut = c;
            end
            if (ownerOut >= 0) lgOut = ownerOut;
        end else begin
            expGv = 1'b1;
            expBv = !empty[ownerIn[1:0]];
            if (expBv && ready) begin
                expPop = 4'b0001 << ownerIn;
                if (last[ownerIn[1:0]]) begin
                    ownerOut = -1;
                    rrOut    = (ownerIn + 1) % m;
                end
            end
        end
    endtask

    // Runs one clock cycle. It drives the queued inputs just after the edge,
    // samples the outputs before the falling edge, compares them with the
    // model, and then advances the model to the next edge.
    task automatic applyStimulus();
        int         dA[4];
        int         dB[4];
        logic       eGv, eBv;
        logic [3:0] ePop;
        int         o, r, l;
        @(posedge ACLK);
        #1;
        ARESETn = nRst;
        emptyA  = nEmptyA; lastA = nLastA; readyA = nReadyA;
        emptyB  = nEmptyB; lastB = nLastB; readyB = nReadyB;
        for (int i = 0; i < 4; i++) destA[i] = nDestA[i];
        for (int i = 0; i < 3; i++) destB[i] = nDestB[i];
        #3;
        for (int i = 0; i < 4; i++) dA[i] = int'(destA[i]);
        for (int i = 0; i < 3; i++) dB[i] = int'(destB[i]);
        dB[3] = 0;

        modelStep(4, 0, emptyA, dA, lastA, readyA, ARESETn,
                  ownerA, rrA, lgA, eGv, eBv, ePop, o, r, l);
        if (checksOn) begin
            checkOutput("A_grant_valid", 32'(gvA), 32'(eGv));
            checkOutput("A_beat_valid", 32'(bvA), 32'(eBv));
            checkOutput("A_fifo_pop", 32'(popA), 32'(ePop));
            checkOutput("A_grant_num", 32'(gmA), 32'(lgA));
            checkOutput("A_rr_ptr", 32'(dutA.rr_ptr), 32'(rrA));
        end
        ownerA = o; rrA = r; lgA = l;

        modelStep(3, 2, {1'b1, emptyB}, dB, {1'b0, lastB}, readyB, ARESETn,
                  ownerB, rrB, lgB, eGv, eBv, ePop, o, r, l);
        if (checksOn) begin
            checkOutput("B_grant_valid", 32'(gvB), 32'(eGv));
            checkOutput("B_beat_valid", 32'(bvB), 32'(eBv));
            checkOutput("B_fifo_pop", 32'({1'b0, popB}), 32'(ePop));
            checkOutput("B_grant_num", 32'(gmB), 32'(lgB));
            checkOutput("B_rr_ptr", 32'(dutB.rr_ptr), 32'(rrB));
        end
        ownerB = o; rrB = r; lgB = l;
        checksOn = 1'b1;
    endtask

    // Directed scenarios first, then randomized traffic with occasional
    // resets.
    initial begin
        logic readyTab[6];
        logic lastTab[6];
        readyTab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        lastTab  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        ARESETn = 1'b0; emptyA = 4'hF; lastA = 4'h0; readyA = 1'b0;
        emptyB = 3'h7; lastB = 3'h0; readyB = 1'b0;
        for (int i = 0; i < 4; i++) begin destA[i] = 1'b0; nDestA[i] = 1'b0; end
        for (int i = 0; i < 3; i++) begin destB[i] = 2'd2; nDestB[i] = 2'd2; end
        nRst = 1'b0; nEmptyA = 4'hF; nLastA = 4'h0; nReadyA = 1'b1;
        nEmptyB = 3'h7; nLastB = 3'h0; nReadyB = 1'b1;

        applyStimulus();
        applyStimulus();
        checkOutput("reset_grant_valid", 32'(gvA), 32'd0);
        checkOutput("reset_grant_num", 32'(gmA), 32'd0);
        nRst = 1'b1;
        applyStimulus();

        // Only M2 requests: a 1-beat burst, granted one cycle later.
        nEmptyA = 4'b1011; nLastA = 4'b0100;
        applyStimulus();
        applyStimulus();
        checkOutput("tp1_grant_valid", 32'(gvA), 32'd1);
        checkOutput("tp1_grant_num", 32'(gmA), 32'd2);
        checkOutput("tp1_pop", 32'(popA), 32'h4);
        nEmptyA = 4'hF;
        applyStimulus();
        checkOutput("tp1_rr_ptr", 32'(dutA.rr_ptr), 32'd3);

        // M0 and M1 request continuously with 1-beat bursts.
        nEmptyA = 4'b1100; nLastA = 4'hF;
        for (int i = 0; i < 8; i++) applyStimulus();
        nEmptyA = 4'hF;
        applyStimulus();

        // A single M0 burst parks the pointer on M1. M1 then runs a 4-beat
        // burst with one stalled cycle while M0 keeps requesting.
        nEmptyA = 4'b1110; nLastA = 4'b0001;
        applyStimulus();
        applyStimulus();
        nEmptyA = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            nReadyA = readyTab[i];
            nLastA  = {2'b00, lastTab[i], 1'b1};
            applyStimulus();
            if (i == 2) checkOutput("tp3_stall_pop", 32'(popA), 32'd0);
        end
        nReadyA = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("tp3_m0_after", 32'(gmA), 32'd0);
        nEmptyA = 4'hF;
        applyStimulus();

        // M3 is granted. Its FIFO runs dry for three cycles, then the burst
        // completes.
        nEmptyA = 4'b0111; nLastA = 4'b0000;
        applyStimulus();
        applyStimulus();
        nEmptyA = 4'hF;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("tp4_hold_valid", 32'(gvA), 32'd1);
        nEmptyA = 4'b0111;
        applyStimulus();
        nLastA = 4'b1000;
        applyStimulus();
        nEmptyA = 4'hF;
        applyStimulus();

        // M0 targets slave 1, so this instance never grants it.
        nEmptyA = 4'b1110; nDestA[0] = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("tp5_no_grant", 32'(gvA), 32'd0);
        nEmptyA = 4'hF; nDestA[0] = 1'b0;

        // Three-master instance: move the pointer to 1, then an M2 burst
        // wraps it to 0.
        nEmptyB = 3'b110; nLastB = 3'b111;
        applyStimulus();
        applyStimulus();
        nEmptyB = 3'b111;
        applyStimulus();
        checkOutput("tp6_rr_one", 32'(dutB.rr_ptr), 32'd1);
        nEmptyB = 3'b011;
        applyStimulus();
        applyStimulus();
        nEmptyB = 3'b111;
        applyStimulus();
        checkOutput("tp6_wrap", 32'(dutB.rr_ptr), 32'd0);

        // Reset arrives in the middle of an M1 burst.
        nEmptyB = 3'b101; nLastB = 3'b000;
        applyStimulus();
        applyStimulus();
        nRst = 1'b0;
        applyStimulus();
        checkOutput("tp6_reset_pop", 32'(popB), 32'd0);
        nRst = 1'b1; nEmptyB = 3'b111;
        applyStimulus();
        checkOutput("tp6_reset_idle", 32'(gvB), 32'd0);
        checkOutput("tp6_reset_rr", 32'(dutB.rr_ptr), 32'd1 - 32'd1);

        // Randomized traffic on both instances.
        for (int cyc = 0; cyc < 400; cyc++) begin
            nRst = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 4; i++) begin
                nEmptyA[i] = ($urandom_range(0, 9) < 3);
                nLastA[i]  = ($urandom_range(0, 9) < 4);
                nDestA[i]  = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 3; i++) begin
                nEmptyB[i] = ($urandom_range(0, 9) < 3);
                nLastB[i]  = ($urandom_range(0, 9) < 4);
                nDestB[i]  = 2'($urandom_range(0, 3));
            end
            nReadyA = ($urandom_range(0, 3) != 0);
            nReadyB = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
